// File: rtl/arrow_spawner_pkg.sv
`default_nettype none
// ============================================================================
// game_pkg : stage codes, lane indices, pacing defaults and FSM encoding
//            shared by the arrow spawner and the VGA arrow tracker.
// Rev 1.0
// ============================================================================
package game_pkg;

   localparam logic [1:0] STAGE1 = 2'b00;
   localparam logic [1:0] STAGE2 = 2'b01;
   localparam logic [1:0] STAGE3 = 2'b10;

   localparam logic [1:0] LANE_D = 2'd0;
   localparam logic [1:0] LANE_U = 2'd1;
   localparam logic [1:0] LANE_L = 2'd2;
   localparam logic [1:0] LANE_R = 2'd3;

   localparam int GAP_S1_DEFAULT      = 60;
   localparam int GAP_S2_DEFAULT      = 40;
   localparam int GAP_S3_DEFAULT      = 20;
   localparam int JITTER_BITS_DEFAULT = 4;

   localparam logic [15:0] LFSR_SEED_DEFAULT = 16'hACE1;
   localparam logic [15:0] LFSR_POLY         = 16'hB400;

   typedef logic [1:0] state_t;
   localparam state_t ST_WAIT = 2'd0;
   localparam state_t ST_PICK = 2'd1;
   localparam state_t ST_EMIT = 2'd2;

   // One step of the right-shifting Galois LFSR (x^16+x^14+x^13+x^11).
   function automatic logic [15:0] lfsr_next(input logic [15:0] v);
      return v[0] ? ((v >> 1) ^ LFSR_POLY) : (v >> 1);
   endfunction

endpackage
`default_nettype wire

// File: rtl/arrow_spawner_if.sv
`default_nettype none
// ============================================================================
// arrow_spawner_if : game-side pacing inputs and spawn outputs of the spawner.
// Rev 1.0
// ============================================================================
interface arrow_spawner_if;
   logic        frame_tick;
   logic        enable;
   logic [1:0]  stage;
   logic [3:0]  lane_busy;
   logic [3:0]  spawn;
   logic [15:0] spawn_count;
   logic [7:0]  cooldown;

   modport master (
      output frame_tick, enable, stage, lane_busy,
      input  spawn, spawn_count, cooldown
   );

   modport slave (
      input  frame_tick, enable, stage, lane_busy,
      output spawn, spawn_count, cooldown
   );
endinterface
`default_nettype wire

// File: rtl/arrow_spawner_lfsr16.sv
`default_nettype none
// ============================================================================
// lfsr16 : free-running 16-bit Galois LFSR; a zero seed is forced to 1.
// Rev 1.0
// ============================================================================
module lfsr16
   import game_pkg::*;
#(
   parameter logic [15:0] SEED = LFSR_SEED_DEFAULT
) (
   input  logic        pclk,
   input  logic        rst,
   output logic [15:0] value
);

   localparam logic [15:0] SEED_NZ = (SEED == 16'h0000) ? 16'h0001 : SEED;

   logic [15:0] lfsr_q;
   logic [15:0] lfsr_d;

   always_comb begin
      lfsr_d = lfsr_next(lfsr_q);
   end

   always_ff @(posedge pclk) begin
      if (rst) begin
         lfsr_q <= SEED_NZ;
      end else begin
         lfsr_q <= lfsr_d;
      end
   end

   assign value = lfsr_q;

endmodule
`default_nettype wire

// File: rtl/arrow_spawner.sv
`default_nettype none
// ============================================================================
// arrow_spawner : frame-paced, stage-scaled, LFSR-jittered arrow launcher that
//                 strobes one free lane per spawn.
// Rev 1.0
// ============================================================================
module arrow_spawner
   import game_pkg::*;
#(
   parameter logic [15:0] SEED        = LFSR_SEED_DEFAULT,
   parameter int          GAP_S1      = GAP_S1_DEFAULT,
   parameter int          GAP_S2      = GAP_S2_DEFAULT,
   parameter int          GAP_S3      = GAP_S3_DEFAULT,
   parameter int          JITTER_BITS = JITTER_BITS_DEFAULT
) (
   input  logic             pclk,
   input  logic             rst,
   arrow_spawner_if.slave   bus
);

   logic [15:0] lfsr_w;
   logic        unused_lfsr;
   logic        tick_en;
   logic [7:0]  reload;

   state_t      state_q, state_d;
   logic [1:0]  cand_q, cand_d;
   logic [1:0]  tries_q, tries_d;
   logic [7:0]  cooldown_q, cooldown_d;
   logic [3:0]  spawn_q, spawn_d;
   logic [15:0] spawn_count_q, spawn_count_d;

   lfsr16 #(.SEED(SEED)) u_lfsr (
      .pclk  (pclk),
      .rst   (rst),
      .value (lfsr_w)
   );

   // Only the low bits feed lane choice and jitter.
   assign unused_lfsr = ^lfsr_w;
   assign tick_en     = bus.frame_tick & bus.enable;

   always_comb begin
      case (bus.stage)
         STAGE1:  reload = 8'(GAP_S1);
         STAGE2:  reload = 8'(GAP_S2);
         default: reload = 8'(GAP_S3);
      endcase
      reload = reload + 8'(lfsr_w[JITTER_BITS-1:0]);
   end

   // State register
   always_ff @(posedge pclk) begin
      if (rst) begin
         state_q <= ST_WAIT;
         cand_q  <= 2'd0;
         tries_q <= 2'd0;
      end else begin
         state_q <= state_d;
         cand_q  <= cand_d;
         tries_q <= tries_d;
      end
   end

   // Next-state: PICK walks the lanes from a random start, at most four.
   always_comb begin
      state_d = state_q;
      cand_d  = cand_q;
      tries_d = tries_q;
      case (state_q)
         ST_WAIT: begin
            if (tick_en && (cooldown_q == 8'd0)) begin
               state_d = ST_PICK;
               cand_d  = lfsr_w[1:0];
               tries_d = 2'd0;
            end
         end
         ST_PICK: begin
            if (!bus.enable) begin
               state_d = ST_WAIT;
            end else if (!bus.lane_busy[cand_q]) begin
               state_d = ST_EMIT;
            end else if (tries_q == 2'd3) begin
               state_d = ST_WAIT;
            end else begin
               cand_d  = cand_q + 2'd1;
               tries_d = tries_q + 2'd1;
            end
         end
         ST_EMIT: state_d = ST_WAIT;
         default: state_d = ST_WAIT;
      endcase
   end

   // Outputs: spawn is registered so it lines up with the EMIT state.
   always_comb begin
      cooldown_d    = cooldown_q;
      spawn_count_d = spawn_count_q;
      spawn_d       = (state_d == ST_EMIT) ? (4'b0001 << cand_d) : 4'b0000;
      case (state_q)
         ST_WAIT: begin
            if (tick_en && (cooldown_q != 8'd0)) begin
               cooldown_d = cooldown_q - 8'd1;
            end
         end
         ST_EMIT: begin
            cooldown_d = reload;
            if (spawn_count_q != 16'hFFFF) begin
               spawn_count_d = spawn_count_q + 16'd1;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge pclk) begin
      if (rst) begin
         cooldown_q    <= 8'(GAP_S1);
         spawn_q       <= 4'b0000;
         spawn_count_q <= 16'h0000;
      end else begin
         cooldown_q    <= cooldown_d;
         spawn_q       <= spawn_d;
         spawn_count_q <= spawn_count_d;
      end
   end

   assign bus.spawn       = spawn_q;
   assign bus.spawn_count = spawn_count_q;
   assign bus.cooldown    = cooldown_q;

endmodule
`default_nettype wire

// File: doc/arrow_spawner.md
Name: arrow_spawner

Overview:
- Upstream feeder of the falling-arrow tracker in the VGA game path.
- Decides when and in which lane (down, up, left, right) a new arrow launches.
- Emits one-cycle per-lane spawn strobes, replacing the tracker's ad-hoc rand==5 trigger.
- Pacing: frame-based cooldown scaled by game stage, jittered by an internal LFSR; a lane still holding a visible arrow is never targeted.

Parameters:
- SEED, 16'hACE1, LFSR reset value; must be non-zero, and 0 is replaced by 16'h0001.
- GAP_S1, 60, base cooldown in frames for stage1 (2'b00).
- GAP_S2, 40, base cooldown in frames for stage2 (2'b01).
- GAP_S3, 20, base cooldown in frames for stage3 (2'b10) and 2'b11.
- JITTER_BITS, 4, number of LFSR bits added to the cooldown (0..15 extra frames).

Ports:
- pclk  in  1  pixel clock, 25 MHz; the only clock.
- rst  in  1  synchronous reset, active-high.
- frame_tick  in  1  one-cycle pulse per frame (hc==0 && vc==0).
- enable  in  1  game running; when low, no spawns and cooldown frozen.
- stage  in  2  current stage code.
- lane_busy  in  4  visible flags {r,l,u,d}; bit0 = down lane.
- spawn  out  4  one-hot one-cycle launch strobe, same bit order.
- spawn_count  out  16  total arrows launched, saturates at 16'hFFFF.
- cooldown  out  8  frames remaining before the next spawn attempt (debug).

Behaviour:
- LFSR: 16-bit Galois, taps x^16+x^14+x^13+x^11, polynomial 16'hB400 shifted right.
  - Advances every pclk regardless of enable or state.
  - Reset loads SEED.
- Reset values:
  - spawn=0, spawn_count=0, cooldown=GAP_S1, state=WAIT.
  - try counter=0, cand lane=0.
- FSM states: WAIT, PICK, EMIT.
- WAIT:
  - On frame_tick && enable with cooldown>0: cooldown decrements by 1.
  - On frame_tick && enable with cooldown==0: go to PICK and latch cand=lfsr[1:0], tries=0.
  - frame_tick with enable low: ignored.
- PICK, one lane checked per cycle:
  - If lane_busy[cand]==0: go to EMIT.
  - Else cand=cand+1 (mod 4), tries=tries+1.
  - If tries==3 and that lane is also busy: return to WAIT with cooldown=0, so a retry happens on the next enabled frame_tick.
  - If enable drops in PICK: return to WAIT, cooldown unchanged (0).
- EMIT, exactly one cycle:
  - spawn[cand]=1; spawn_count increments unless already at 16'hFFFF.
  - Reload cooldown = base(stage) + lfsr[JITTER_BITS-1:0], zero-extended to 8 bits; the stage value is sampled in this cycle.
  - Next state WAIT.
- Timing rules:
  - spawn is registered, all other cycles 0. Never more than one bit set.
  - Latency: first frame_tick with cooldown==0 → spawn asserted 2–5 cycles later (PICK 1–4 cycles + EMIT).
  - frame_tick arriving during PICK/EMIT: ignored. The cooldown loaded in EMIT starts counting at the next tick.
  - A stage change mid-cooldown does not rescale the current cooldown; it applies at the next EMIT.
  - lane_busy is sampled combinationally in PICK. A lane going busy on the EMIT cycle is not rechecked.
- rst asserted in any state:
  - Next cycle shows reset values.
  - A spawn strobe that would have occurred is suppressed.
- Max cooldown GAP_S1+15=75 fits 8 bits. Parameter values must keep base+2^JITTER_BITS-1 ≤ 255.

Decomposition:
- Shared package (game_pkg): stage codes STAGE1/2/3, lane index constants LANE_D=0/U=1/L=2/R=3, and GAP_S* defaults. The VGA tracker uses the same constants.
- One natural sub-module, lfsr16: SEED parameter, pclk, rst, 16-bit out.
- FSM, cooldown and counter stay in arrow_spawner.

Test Plan:
- Reset: assert rst 3 cycles → spawn=0, spawn_count=0, cooldown=60, LFSR=16'hACE1; release.
  - With enable=1, stage=0, after 60 frame_ticks cooldown reads 0.
  - Next tick gives exactly one one-hot spawn within 5 cycles; spawn_count=1; cooldown reloaded to 60..75.
- Busy skip: lane_busy=4'b0111, force cand=0 via SEED choice → spawn=4'b1000 after 4 PICK cycles.
- All busy: lane_busy=4'hF at the spawn tick → no spawn, cooldown stays 0.
  - Clear lane_busy to 4'b1101 before the next tick → spawn=4'b0010 on that tick.
- Stage scaling: stage=2'b10 at EMIT → reloaded cooldown within 20..35; stage=2'b11 gives the same range.
- Enable gating: enable=0 for 100 frame_ticks → cooldown unchanged, no spawn.
  - Drop enable during PICK → return to WAIT, no spawn.
- Saturation/reset mid-op: preload spawn_count=16'hFFFE, trigger 2 spawns → count ends at 16'hFFFF.
  - Assert rst on the PICK cycle → no spawn, all reset values next cycle.
